// File: rtl/mem_pkg.sv
// Shared definitions for the data memory responder: funct3 size codes, FSM encoding and
// request legality helpers.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StAccess  = 2'd1,
        StRespond = 2'd2
    } state_t;

    // funct3[1:0] encodes log2 of the access size in bytes.
    function automatic logic misaligned(input logic [2:0] funct3, input logic [2:0] offset);
        logic r;
        case (funct3[1:0])
            2'd0:    r = 1'b0;
            2'd1:    r = offset[0];
            2'd2:    r = |offset[1:0];
            default: r = |offset;
        endcase
        return r;
    endfunction

    function automatic logic illegal_funct3(input logic write, input logic [2:0] funct3);
        return write ? funct3[2] : (funct3 == 3'b111);
    endfunction

endpackage

// File: rtl/load_extend.sv
// Byte-lane selection: extracts and extends load data from a storage word, and merges store
// data into the size-selected lanes of a storage word.
module load_extend
    import mem_pkg::*;
#(
    parameter int WORDSIZE = 64
) (
    input  logic [WORDSIZE-1:0] i_word,
    input  logic [WORDSIZE-1:0] i_wdata,
    input  logic [2:0]          i_offset,
    input  logic [2:0]          i_funct3,
    output logic [WORDSIZE-1:0] o_load,
    output logic [WORDSIZE-1:0] o_store
);

    logic [5:0]          w_shamt;
    logic [WORDSIZE-1:0] w_shifted;
    logic [WORDSIZE-1:0] w_size_mask;
    logic [WORDSIZE-1:0] w_lane_mask;

    assign w_shamt   = {i_offset, 3'b000};
    assign w_shifted = i_word >> w_shamt;

    always_comb begin
        o_load = w_shifted;
        case (i_funct3)
            F3_B:    o_load = {{(WORDSIZE-8){w_shifted[7]}}, w_shifted[7:0]};
            F3_H:    o_load = {{(WORDSIZE-16){w_shifted[15]}}, w_shifted[15:0]};
            F3_W:    o_load = {{(WORDSIZE-32){w_shifted[31]}}, w_shifted[31:0]};
            F3_BU:   o_load = {{(WORDSIZE-8){1'b0}}, w_shifted[7:0]};
            F3_HU:   o_load = {{(WORDSIZE-16){1'b0}}, w_shifted[15:0]};
            F3_WU:   o_load = {{(WORDSIZE-32){1'b0}}, w_shifted[31:0]};
            F3_D:    o_load = w_shifted;
            default: o_load = w_shifted;
        endcase
    end

    always_comb begin
        w_size_mask = '1;
        case (i_funct3[1:0])
            2'd0:    w_size_mask = {{(WORDSIZE-8){1'b0}}, 8'hFF};
            2'd1:    w_size_mask = {{(WORDSIZE-16){1'b0}}, 16'hFFFF};
            2'd2:    w_size_mask = {{(WORDSIZE-32){1'b0}}, 32'hFFFF_FFFF};
            default: w_size_mask = '1;
        endcase
    end

    assign w_lane_mask = w_size_mask << w_shamt;
    assign o_store     = (i_word & ~w_lane_mask) | ((i_wdata << w_shamt) & w_lane_mask);

endmodule

// File: rtl/data_mem_responder.sv
// Word-organised data memory with a valid/ready request port, fixed access latency and a
// held response, supporting RISC-V sized and sign/zero-extended loads and stores.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int WORDSIZE    = 64,
    parameter int DEPTH       = 32,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_req_valid,
    output logic                o_req_ready,
    input  logic                i_req_write,
    input  logic [2:0]          i_req_funct3,
    input  logic [WORDSIZE-1:0] i_req_addr,
    input  logic [WORDSIZE-1:0] i_req_wdata,
    output logic                o_rsp_valid,
    input  logic                i_rsp_ready,
    output logic [WORDSIZE-1:0] o_rsp_rdata,
    output logic                o_rsp_fault,
    output logic                o_busy
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [WORDSIZE-4:0] DEPTH_W  = (WORDSIZE-3)'(DEPTH);

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_write;
    logic [2:0]          r_funct3;
    logic [WORDSIZE-1:0] r_addr;
    logic [WORDSIZE-1:0] r_wdata;
    logic                r_rsp_valid;
    logic                r_rsp_fault;
    logic [WORDSIZE-1:0] r_rsp_rdata;
    logic [WORDSIZE-1:0] r_mem [DEPTH];

    logic [IDX_W-1:0]    w_idx;
    logic [WORDSIZE-4:0] w_word_idx;
    logic                w_fault;
    logic                w_last;
    logic                w_commit;
    logic [WORDSIZE-1:0] w_rd_word;
    logic [WORDSIZE-1:0] w_load;
    logic [WORDSIZE-1:0] w_store;

    assign w_idx      = r_addr[3 +: IDX_W];
    assign w_word_idx = r_addr[WORDSIZE-1:3];
    assign w_fault    = misaligned(r_funct3, r_addr[2:0]) || (w_word_idx >= DEPTH_W) ||
                        illegal_funct3(r_write, r_funct3);
    assign w_last     = (r_state == StAccess) && (r_cnt == CNT_LAST);
    // Reset forces r_state to idle asynchronously, so a pending store can never commit.
    assign w_commit   = w_last && r_write && !w_fault;
    assign w_rd_word  = r_mem[w_idx];

    load_extend #(
        .WORDSIZE (WORDSIZE)
    ) u_load_extend (
        .i_word   (w_rd_word),
        .i_wdata  (r_wdata),
        .i_offset (r_addr[2:0]),
        .i_funct3 (r_funct3),
        .o_load   (w_load),
        .o_store  (w_store)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_write     <= 1'b0;
            r_funct3    <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_fault <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (i_req_valid) begin
                        r_state  <= StAccess;
                        r_cnt    <= '0;
                        r_write  <= i_req_write;
                        r_funct3 <= i_req_funct3;
                        r_addr   <= i_req_addr;
                        r_wdata  <= i_req_wdata;
                    end
                end
                StAccess: begin
                    if (w_last) begin
                        r_state     <= StRespond;
                        r_cnt       <= '0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_fault <= w_fault;
                        r_rsp_rdata <= (w_fault || r_write) ? '0 : w_load;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StRespond: begin
                    if (i_rsp_ready) begin
                        r_state     <= StIdle;
                        r_rsp_valid <= 1'b0;
                        r_rsp_fault <= 1'b0;
                        r_rsp_rdata <= '0;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // Storage has no reset so its contents survive one.
    always_ff @(posedge i_clk) begin
        if (w_commit) begin
            r_mem[w_idx] <= w_store;
        end
    end

    assign o_req_ready = (r_state == StIdle);
    assign o_busy      = (r_state != StIdle);
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_fault = r_rsp_fault;
    assign o_rsp_rdata = r_rsp_rdata;

endmodule
